// File: rtl/upd78xx_imem_pkg.sv
// upd78xx_imem_pkg: shared types, limits and address-decode helper for the uPD78xx internal memory block
package upd78xx_imem_pkg;

    typedef enum logic {CLEAR, RUN} clr_state_t;

    localparam int unsigned EXT_WAIT_MAX = 15;

    // True when addr falls in the aligned 2^width window that contains base
    function automatic logic addr_match(input logic [15:0] addr, input logic [15:0] base,
                                        input int unsigned width);
        return (addr >> width) == (base >> width);
    endfunction

endpackage

// File: rtl/upd78xx_imem_if.sv
// upd78xx_imem_if: core-side and pin-side bus of the uPD78xx internal memory block
//   core_*     : core address/data/strobes in, read data and wait request out
//   a/db/rdb/wrb: external pin bus, ext_waitb is the external wait request
//   master = core/pin driver side, slave = memory subsystem
interface upd78xx_imem_if;
    logic [15:0] core_a;
    logic [7:0]  core_db_o;
    logic        core_db_oe;
    logic        core_rdb;
    logic        core_wrb;
    logic [7:0]  core_db_i;
    logic        core_waitb;
    logic [15:0] a;
    logic        a_oe;
    logic [7:0]  db_i;
    logic [7:0]  db_o;
    logic        db_oe;
    logic        rdb;
    logic        wrb;
    logic        ext_waitb;

    modport master (
        output core_a, core_db_o, core_db_oe, core_rdb, core_wrb, db_i, ext_waitb,
        input  core_db_i, core_waitb, a, a_oe, db_o, db_oe, rdb, wrb
    );

    modport slave (
        input  core_a, core_db_o, core_db_oe, core_rdb, core_wrb, db_i, ext_waitb,
        output core_db_i, core_waitb, a, a_oe, db_o, db_oe, rdb, wrb
    );
endinterface

// File: rtl/upd78xx_spram.sv
// upd78xx_spram: 2^AW x 8 memory, synchronous write, registered read (read-during-write returns old data)
//   clk_i, we_i, waddr_i, wdata_i : write port
//   raddr_i -> rdata_o            : registered read port
module upd78xx_spram #(
    parameter int unsigned AW = 7
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);
    logic [7:0] mem_q [2**AW];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/upd78xx_imem.sv
// upd78xx_imem: mask ROM, self-clearing work RAM, address decode, read steering and external wait generator
//   clk_i/rst_i            : clock, synchronous active-high reset
//   rom_en_i               : 1 = internal ROM decoded, 0 = ROM range goes external
//   init_*_i               : ROM load port (usable during reset)
//   busy_o                 : RAM clear in progress
//   bus                    : core and external pin bus
module upd78xx_imem #(
    parameter int unsigned ROM_AW    = 12,
    parameter int unsigned RAM_AW    = 7,
    parameter logic [15:0] RAM_BASE  = 16'hFF80,
    parameter int unsigned EXT_WAIT  = 0,
    parameter bit          CLEAR_RAM = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rom_en_i,
    input  logic              init_sel_i,
    input  logic [ROM_AW-1:0] init_addr_i,
    input  logic [7:0]        init_data_i,
    input  logic              init_valid_i,
    output logic              busy_o,
    upd78xx_imem_if.slave     bus
);
    import upd78xx_imem_pkg::*;

    localparam logic [3:0] WAIT_LOAD = 4'(EXT_WAIT > EXT_WAIT_MAX ? EXT_WAIT_MAX : EXT_WAIT);

    clr_state_t        state_q, state_d;
    logic [RAM_AW-1:0] clr_addr_q, clr_addr_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic              acc_q, rom_sel_q, ram_sel_q;
    logic              rom_sel, ram_sel, ext_sel, acc, load_cycle;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_waddr;
    logic [7:0]        ram_wdata, rom_q, ram_q;

    assign rom_sel    = rom_en_i & addr_match(bus.core_a, 16'h0000, ROM_AW);
    assign ram_sel    = addr_match(bus.core_a, RAM_BASE, RAM_AW);
    assign ext_sel    = ~rom_sel & ~ram_sel;
    assign acc        = ext_sel & (~bus.core_rdb | ~bus.core_wrb);
    assign load_cycle = acc & ~acc_q;
    assign busy_o     = (state_q == CLEAR);

    assign bus.a_oe  = ~rst_i & ext_sel;
    assign bus.a     = bus.a_oe ? bus.core_a : 16'h0000;
    assign bus.db_oe = bus.core_db_oe & bus.a_oe;
    assign bus.db_o  = bus.db_oe ? bus.core_db_o : 8'h00;
    assign bus.rdb   = bus.core_rdb | ~bus.a_oe;
    assign bus.wrb   = bus.core_wrb | ~bus.a_oe;

    assign bus.core_db_i = bus.core_db_oe ? bus.core_db_o :
                           rom_sel_q      ? rom_q        :
                           ram_sel_q      ? ram_q        : bus.db_i;

    // A zero-wait configuration adds no stall on the strobe edge itself
    assign bus.core_waitb = bus.ext_waitb & ~busy_o & (wcnt_q == 4'd0) &
                            ~(load_cycle & (WAIT_LOAD != 4'd0));

    // The clear sweep owns the RAM write port; core writes are dropped meanwhile
    assign ram_we    = busy_o | (ram_sel & ~bus.core_wrb);
    assign ram_waddr = busy_o ? clr_addr_q : bus.core_a[RAM_AW-1:0];
    assign ram_wdata = busy_o ? 8'h00 : bus.core_db_o;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        wcnt_d     = load_cycle ? WAIT_LOAD : (wcnt_q != 4'd0 ? wcnt_q - 4'd1 : 4'd0);
        if (state_q == CLEAR) begin
            clr_addr_d = clr_addr_q + RAM_AW'(1);
            if (&clr_addr_q) state_d = RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= CLEAR_RAM ? CLEAR : RUN;
            clr_addr_q <= '0;
            wcnt_q     <= 4'd0;
            acc_q      <= 1'b0;
            rom_sel_q  <= 1'b0;
            ram_sel_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            wcnt_q     <= wcnt_d;
            acc_q      <= acc;
            rom_sel_q  <= rom_sel;
            ram_sel_q  <= ram_sel;
        end
    end

    upd78xx_spram #(.AW(ROM_AW)) u_rom (
        .clk_i   (clk_i),
        .we_i    (init_sel_i & init_valid_i),
        .waddr_i (init_addr_i),
        .wdata_i (init_data_i),
        .raddr_i (bus.core_a[ROM_AW-1:0]),
        .rdata_o (rom_q)
    );

    upd78xx_spram #(.AW(RAM_AW)) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (bus.core_a[RAM_AW-1:0]),
        .rdata_o (ram_q)
    );
endmodule

// File: tb/tb_upd78xx_imem.sv
// tb_upd78xx_imem: directed self-checking bench for upd78xx_imem (EXT_WAIT = 3, CLEAR_RAM = 1)
module tb_upd78xx_imem;
    logic        clk = 1'b0;
    logic        rst;
    logic        rom_en, init_sel, init_valid;
    logic [11:0] init_addr;
    logic [7:0]  init_data;
    logic        busy;
    int          errors = 0;
    int          checks = 0;
    int          n;
    int          bad;

    upd78xx_imem_if bus ();

    upd78xx_imem #(
        .ROM_AW(12), .RAM_AW(7), .RAM_BASE(16'hFF80), .EXT_WAIT(3), .CLEAR_RAM(1'b1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rom_en_i     (rom_en),
        .init_sel_i   (init_sel),
        .init_addr_i  (init_addr),
        .init_data_i  (init_data),
        .init_valid_i (init_valid),
        .busy_o       (busy),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle;
        bus.core_rdb   = 1'b1;
        bus.core_wrb   = 1'b1;
        bus.core_db_oe = 1'b0;
        bus.core_db_o  = 8'h00;
    endtask

    initial begin
        rst = 1'b1; rom_en = 1'b1; init_sel = 1'b1; init_valid = 1'b0;
        init_addr = 12'h000; init_data = 8'h00;
        bus.core_a = 16'h0000; bus.db_i = 8'h77; bus.ext_waitb = 1'b1;
        idle();
        step();
        // ROM load during reset, with an external-looking access that reset must mask
        init_addr = 12'h010; init_data = 8'hA5; init_valid = 1'b1;
        bus.core_a = 16'h2000; bus.core_rdb = 1'b0; bus.core_wrb = 1'b0;
        bus.core_db_oe = 1'b1; bus.core_db_o = 8'h66;
        step();
        init_valid = 1'b0;
        #1;
        chk("rst_busy", 16'(busy), 16'h1);
        chk("rst_waitb", 16'(bus.core_waitb), 16'h0);
        chk("rst_a_oe", 16'(bus.a_oe), 16'h0);
        chk("rst_a", bus.a, 16'h0000);
        chk("rst_db_oe", 16'(bus.db_oe), 16'h0);
        chk("rst_db_o", 16'(bus.db_o), 16'h00);
        chk("rst_rdb", 16'(bus.rdb), 16'h1);
        chk("rst_wrb", 16'(bus.wrb), 16'h1);
        idle();
        bus.core_a = 16'h0000;
        step();
        // Release reset with a core write to FF80 pending; clear must discard it
        rst = 1'b0;
        bus.core_a = 16'hFF80; bus.core_db_o = 8'h3C; bus.core_db_oe = 1'b1; bus.core_wrb = 1'b0;
        n = 0;
        while (busy && n < 300) begin
            n++;
            if (n == 3) idle();
            step();
        end
        chk("clear_len", 16'(n), 16'd128);
        chk("run_waitb", 16'(bus.core_waitb), 16'h1);
        bus.core_a = 16'hFF85; bus.core_rdb = 1'b0;
        step();
        chk("ram_ff85", 16'(bus.core_db_i), 16'h00);
        bus.core_a = 16'hFF80;
        step();
        chk("ram_wr_in_clear", 16'(bus.core_db_i), 16'h00);
        // Write after clear; readback the cycle of the write gives old data
        bus.core_rdb = 1'b1; bus.core_wrb = 1'b0; bus.core_db_oe = 1'b1; bus.core_db_o = 8'h3C;
        #1;
        chk("db_oe_steer", 16'(bus.core_db_i), 16'h3C);
        chk("ram_no_ext_wrb", 16'(bus.wrb), 16'h1);
        step();
        idle();
        #1;
        chk("ram_rdw_old", 16'(bus.core_db_i), 16'h00);
        step();
        chk("ram_3c", 16'(bus.core_db_i), 16'h3C);
        // Internal ROM read
        bus.core_a = 16'h0010; bus.core_rdb = 1'b0;
        #1;
        chk("rom_a_oe", 16'(bus.a_oe), 16'h0);
        chk("rom_rdb", 16'(bus.rdb), 16'h1);
        chk("rom_waitb", 16'(bus.core_waitb), 16'h1);
        step();
        chk("rom_a5", 16'(bus.core_db_i), 16'hA5);
        // Same address with ROM disabled goes external
        rom_en = 1'b0;
        #1;
        chk("romless_a_oe", 16'(bus.a_oe), 16'h1);
        chk("romless_a", bus.a, 16'h0010);
        chk("romless_rdb", 16'(bus.rdb), 16'h0);
        step();
        chk("romless_db_i", 16'(bus.core_db_i), 16'h77);
        bus.core_rdb = 1'b1; rom_en = 1'b1;
        repeat (4) step();
        // INIT write concurrent with a read of the same byte
        bus.core_rdb = 1'b0;
        init_addr = 12'h010; init_data = 8'hC3; init_valid = 1'b1;
        step();
        init_valid = 1'b0;
        chk("rom_init_old", 16'(bus.core_db_i), 16'hA5);
        step();
        chk("rom_init_new", 16'(bus.core_db_i), 16'hC3);
        // External read with EXT_WAIT = 3
        bus.core_a = 16'h2000;
        #1;
        n = 0;
        while (!bus.core_waitb && n < 50) begin
            n++;
            step();
        end
        chk("wait_len", 16'(n), 16'd4);
        chk("ext_a", bus.a, 16'h2000);
        chk("ext_rdb", 16'(bus.rdb), 16'h0);
        chk("ext_db_i", 16'(bus.core_db_i), 16'h77);
        bus.core_rdb = 1'b1;
        step();
        // Same access with EXT_WAITB held low for 6 extra clocks
        bus.ext_waitb = 1'b0; bus.core_rdb = 1'b0;
        #1;
        n = 0;
        while (!bus.core_waitb && n < 50) begin
            n++;
            step();
            if (n >= 10) bus.ext_waitb = 1'b1;
            #1;
        end
        chk("wait_ext_len", 16'(n), 16'd10);
        // Back-to-back strobe reloads on the new falling edge
        bus.core_rdb = 1'b1;
        step();
        bus.core_rdb = 1'b0;
        #1;
        chk("b2b_load", 16'(bus.core_waitb), 16'h0);
        step();
        chk("b2b_count", 16'(bus.core_waitb), 16'h0);
        bus.core_rdb = 1'b1;
        repeat (4) step();
        // External write drives the pin bus
        bus.core_wrb = 1'b0; bus.core_db_oe = 1'b1; bus.core_db_o = 8'h5A;
        #1;
        chk("ext_wrb", 16'(bus.wrb), 16'h0);
        chk("ext_db_oe", 16'(bus.db_oe), 16'h1);
        chk("ext_db_o", 16'(bus.db_o), 16'h5A);
        idle();
        repeat (5) step();
        // Fill RAM with nonzero data, then reset mid-clear and confirm a full restart
        for (int i = 0; i < 128; i++) begin
            bus.core_a = 16'hFF80 + 16'(i); bus.core_db_o = 8'h80 | 8'(i);
            bus.core_wrb = 1'b0; bus.core_db_oe = 1'b1;
            step();
        end
        idle();
        bus.core_a = 16'hFFFF;
        step();
        step();
        chk("ram_fill", 16'(bus.core_db_i), 16'hFF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (60) step();
        chk("mid_busy", 16'(busy), 16'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        while (busy && n < 300) begin
            n++;
            step();
        end
        chk("reclear_len", 16'(n), 16'd128);
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            bus.core_a = 16'hFF80 + 16'(i);
            step();
            if (bus.core_db_i !== 8'h00) bad++;
        end
        chk("reclear_zero", 16'(bad), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
